// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: control FSM that steps a multi-cycle floating-point adder
// datapath through LOAD, ALIGN, ADD, NORM and ROUND, with valid/ready handshakes
// on both the operand and the result side.
module fp_add_sequencer #(
    parameter int unsigned NORM_MAX = 24,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             special_case,
    input  logic             norm_done,
    output logic             load_op,
    output logic             align_en,
    output logic             add_en,
    output logic             norm_en,
    output logic             round_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             norm_timeout,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        ROUND = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] norm_cnt;
    logic       in_norm;
    logic       norm_last;

    // norm_en is the only output that reacts to a datapath flag in the same cycle
    assign norm_en   = in_norm & ~norm_done;
    assign norm_last = (norm_cnt == 8'(NORM_MAX - 1));

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = LOAD;
            LOAD:    state_nx = ALIGN;
            ALIGN:   state_nx = special_case ? DONE : ADD;
            ADD:     state_nx = NORM;
            NORM:    if (norm_done || norm_last) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, registered Moore outputs, shift counter, timeout flag and op counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            norm_cnt     <= '0;
            ops_done     <= '0;
            norm_timeout <= 1'b0;
            in_ready     <= 1'b1;
            load_op      <= 1'b0;
            align_en     <= 1'b0;
            add_en       <= 1'b0;
            in_norm      <= 1'b0;
            round_en     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state     <= state_nx;
            // outputs are decoded from the next state so they line up with the state register
            in_ready  <= (state_nx == IDLE);
            load_op   <= (state_nx == LOAD);
            align_en  <= (state_nx == ALIGN);
            add_en    <= (state_nx == ADD);
            in_norm   <= (state_nx == NORM);
            round_en  <= (state_nx == ROUND);
            out_valid <= (state_nx == DONE);
            busy      <= (state_nx != IDLE);

            if (state == IDLE && in_valid) begin
                norm_cnt     <= '0;
                norm_timeout <= 1'b0;
            end else if (norm_en) begin
                norm_cnt <= norm_cnt + 8'd1;
                if (norm_last) norm_timeout <= 1'b1;
            end

            if (state == DONE && out_ready) ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed tests for fp_add_sequencer with hand-computed
// cycle positions. A second instance with a 4-bit op counter shares all inputs
// to exercise counter wrap in a short run.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        reset, in_valid, special_case, norm_done, out_ready;
    logic        in_ready, load_op, align_en, add_en, norm_en, round_en;
    logic        out_valid, busy, norm_timeout;
    logic [15:0] ops_done;
    logic        b_in_ready, b_load_op, b_align_en, b_add_en, b_norm_en, b_round_en;
    logic        b_out_valid, b_busy, b_norm_timeout;
    logic [3:0]  b_ops_done;

    fp_add_sequencer #(.NORM_MAX(24), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .special_case(special_case), .norm_done(norm_done), .load_op(load_op),
        .align_en(align_en), .add_en(add_en), .norm_en(norm_en), .round_en(round_en),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .norm_timeout(norm_timeout), .ops_done(ops_done)
    );

    fp_add_sequencer #(.NORM_MAX(24), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .special_case(special_case), .norm_done(norm_done), .load_op(b_load_op),
        .align_en(b_align_en), .add_en(b_add_en), .norm_en(b_norm_en), .round_en(b_round_en),
        .out_valid(b_out_valid), .out_ready(out_ready), .busy(b_busy),
        .norm_timeout(b_norm_timeout), .ops_done(b_ops_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // per-op observations (cycle 1 = first cycle after the accept edge)
    int c_load, c_align, c_add, c_round, c_ov, first_norm, last_norm;
    int n_load, n_add, n_norm, n_round, multi, n_inrdy;
    logic to_c1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op and observe it until out_valid or max_cyc cycles; ends at the
    // falling edge of the last observed cycle. norm_done rises once done_after
    // norm_en pulses have been seen. glitch holds in_valid high in cycles 1..3.
    task automatic run_op(input bit spec, input int done_after, input int max_cyc, input bit glitch);
        c_load = -1; c_align = -1; c_add = -1; c_round = -1; c_ov = -1;
        first_norm = -1; last_norm = -1;
        n_load = 0; n_add = 0; n_norm = 0; n_round = 0; multi = 0; n_inrdy = 0;
        to_c1 = 1'bx;
        in_valid = 1'b1; special_case = spec; out_ready = 1'b0;
        norm_done = (done_after == 0);
        @(posedge clk); #1;
        in_valid = glitch;
        for (int c = 1; c <= max_cyc; c++) begin
            norm_done = (n_norm >= done_after);
            if (c > 3) in_valid = 1'b0;
            @(negedge clk);
            if (c == 1) to_c1 = norm_timeout;
            if (in_ready) n_inrdy++;
            if ($countones({load_op, align_en, add_en, norm_en, round_en}) > 1) multi++;
            if (load_op)  begin n_load++;  if (c_load  < 0) c_load  = c; end
            if (align_en) begin            if (c_align < 0) c_align = c; end
            if (add_en)   begin n_add++;   if (c_add   < 0) c_add   = c; end
            if (round_en) begin n_round++; if (c_round < 0) c_round = c; end
            if (norm_en)  begin n_norm++;  if (first_norm < 0) first_norm = c; last_norm = c; end
            if (out_valid) begin c_ov = c; break; end
            if (c < max_cyc) begin @(posedge clk); #1; end
        end
    endtask

    // Hold out_ready low for 'hold' cycles in DONE, then complete the handshake.
    // Ends just after the handshake edge.
    task automatic handshake(input int hold);
        int bad = 0;
        logic [15:0] ops0 = ops_done;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!out_valid || in_ready || ops_done != ops0) bad++;
        end
        check("done_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; norm_done = 1'b0; special_case = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; special_case = 1'b0;
        norm_done = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_outputs", 32'({load_op, align_en, add_en, norm_en, round_en, out_valid}), 0);
        check("rst_ops_done", 32'(ops_done), 0);
        check("rst_timeout", 32'(norm_timeout), 0);

        // normal op, two normalise shifts
        run_op(1'b0, 2, 40, 1'b0);
        check("n2_load_cyc", c_load, 1);
        check("n2_align_cyc", c_align, 2);
        check("n2_add_cyc", c_add, 3);
        check("n2_norm_first", first_norm, 4);
        check("n2_norm_last", last_norm, 5);
        check("n2_norm_cnt", n_norm, 2);
        check("n2_round_cyc", c_round, 7);
        check("n2_ov_cyc", c_ov, 8);
        check("n2_onehot", multi, 0);
        check("n2_in_ready_busy", n_inrdy, 0);
        check("n2_timeout", 32'(norm_timeout), 0);
        handshake(0);
        check("n2_ops_done", 32'(ops_done), 1);
        check("n2_idle_ready", 32'(in_ready), 1);
        check("n2_idle_ov", 32'(out_valid), 0);

        // special-case shortcut with stalled consumer
        run_op(1'b1, 0, 40, 1'b0);
        check("sp_align_cyc", c_align, 2);
        check("sp_ov_cyc", c_ov, 3);
        check("sp_no_add", n_add, 0);
        check("sp_no_norm", n_norm, 0);
        check("sp_no_round", n_round, 0);
        handshake(5);
        check("sp_ops_done", 32'(ops_done), 2);
        check("sp_idle_busy", 32'(busy), 0);

        // norm_done never arrives: NORM_MAX shifts then timeout
        run_op(1'b0, 1000, 60, 1'b0);
        check("to_norm_cnt", n_norm, 24);
        check("to_round_cyc", c_round, 28);
        check("to_ov_cyc", c_ov, 29);
        check("to_flag_done", 32'(norm_timeout), 1);
        handshake(0);
        check("to_flag_sticky", 32'(norm_timeout), 1);
        check("to_ops_done", 32'(ops_done), 3);

        // norm_done on what would be the last allowed shift cycle
        run_op(1'b0, 23, 60, 1'b0);
        check("b23_to_cleared", 32'(to_c1), 0);
        check("b23_norm_cnt", n_norm, 23);
        check("b23_ov_cyc", c_ov, 29);
        check("b23_timeout", 32'(norm_timeout), 0);
        handshake(0);
        check("b23_ops_done", 32'(ops_done), 4);

        // norm_done already high at NORM entry, in_valid pulsed while busy
        run_op(1'b0, 0, 40, 1'b1);
        check("k0_norm_cnt", n_norm, 0);
        check("k0_round_cyc", c_round, 5);
        check("k0_ov_cyc", c_ov, 6);
        check("k0_single_load", n_load, 1);
        check("k0_in_ready_busy", n_inrdy, 0);
        handshake(0);
        repeat (2) begin @(posedge clk); #1; end
        check("k0_ignored_busy", 32'(busy), 0);
        check("k0_ops_done", 32'(ops_done), 5);

        // reset in the third NORM cycle
        run_op(1'b0, 1000, 6, 1'b0);
        check("rm_norm_cnt", n_norm, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rm_outputs", 32'({load_op, align_en, add_en, norm_en, round_en, out_valid}), 0);
        check("rm_in_ready", 32'(in_ready), 1);
        check("rm_busy", 32'(busy), 0);
        check("rm_ops_done", 32'(ops_done), 0);
        check("rm_small_ops_done", 32'(b_ops_done), 0);

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) begin
            run_op(1'b1, 0, 10, 1'b0);
            handshake(0);
        end
        check("wr_small_max", 32'(b_ops_done), 15);
        run_op(1'b1, 0, 10, 1'b0);
        check("wr_ov_cyc", c_ov, 3);
        handshake(0);
        check("wr_small_wrap", 32'(b_ops_done), 0);
        check("wr_big_count", 32'(ops_done), 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
